// File: rtl/serial_pattern_gen.sv
// Serial pattern generator: shifts a loaded word out MSB-first,
// repeated back-to-back, followed by an idle gap and a done pulse.
module serial_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_reps,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAPS
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bitcnt, bitcnt_n;
  logic [CNT_W-1:0] repcnt, repcnt_n;
  logic [GW-1:0]    gapcnt, gapcnt_n;
  logic             out_n, valid_n, done_n;
  logic [CNT_W-1:0] reps_clamped;

  assign load_ready   = (state == IDLE) && !reset;
  assign reps_clamped = (load_reps == '0) ? CNT_W'(1) : load_reps;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      repcnt    <= '0;
      gapcnt    <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bitcnt    <= bitcnt_n;
      repcnt    <= repcnt_n;
      gapcnt    <= gapcnt_n;
      out       <= out_n;
      out_valid <= valid_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    repcnt_n = repcnt;
    gapcnt_n = gapcnt;
    out_n    = 1'b0;
    valid_n  = 1'b0;
    done_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          shreg_n  = load_data;
          repcnt_n = reps_clamped;
          bitcnt_n = '0;
          out_n    = load_data[WIDTH-1];
          valid_n  = 1'b1;
          state_n  = SHIFT;
        end
      end
      SHIFT: begin
        // rotate so the word is intact again after WIDTH bits
        shreg_n = {shreg[WIDTH-2:0], shreg[WIDTH-1]};
        if (bitcnt == BLAST) begin
          bitcnt_n = '0;
          if (repcnt > CNT_W'(1)) begin
            repcnt_n = repcnt - CNT_W'(1);
            out_n    = shreg[WIDTH-2];
            valid_n  = 1'b1;
          end else if (GAP > 0) begin
            gapcnt_n = '0;
            state_n  = GAPS;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          bitcnt_n = bitcnt + BW'(1);
          out_n    = shreg[WIDTH-2];
          valid_n  = 1'b1;
        end
      end
      GAPS: begin
        if (gapcnt == GLAST) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          gapcnt_n = gapcnt + GW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen (WIDTH=8, CNT_W=4, GAP=2).
// Frames come from a vector table; hold-off and reset cases are hand-written.
module tb_serial_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic [3:0] load_reps;
  logic       out;
  logic       out_valid;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  reps;
    logic [31:0] bits;
    int          n;
  } vec_t;

  vec_t vecs[4];

  serial_pattern_gen #(
    .WIDTH(8),
    .CNT_W(4),
    .GAP(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .load_reps (load_reps),
    .out       (out),
    .out_valid (out_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // caller is positioned at a negedge; load is accepted at the next posedge
  task automatic send(input logic [7:0] d, input logic [3:0] r);
    load_valid = 1'b1;
    load_data  = d;
    load_reps  = r;
    #1;
    chk("send_ready", {31'b0, load_ready}, 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // checks n contiguous bits, two gap cycles, then stops in the done cycle
  task automatic recv(input string name, input logic [31:0] bits,
                      input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({name, "_valid"}, {31'b0, out_valid}, 32'd1);
      chk({name, "_bit"}, {31'b0, out}, {31'b0, bits[31-i]});
      chk({name, "_busy"}, {31'b0, load_ready}, 32'd0);
      chk({name, "_nodone"}, {31'b0, done}, 32'd0);
    end
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      chk({name, "_gapvalid"}, {31'b0, out_valid}, 32'd0);
      chk({name, "_gapout"}, {31'b0, out}, 32'd0);
      chk({name, "_gapdone"}, {31'b0, done}, 32'd0);
      chk({name, "_gapbusy"}, {31'b0, load_ready}, 32'd0);
    end
    @(negedge clk);
    chk({name, "_done"}, {31'b0, done}, 32'd1);
    chk({name, "_doneready"}, {31'b0, load_ready}, 32'd1);
    chk({name, "_donevalid"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hD8, reps: 4'd1, bits: 32'hD800_0000, n: 8};
    vecs[1] = '{data: 8'hC0, reps: 4'd3, bits: 32'hC0C0_C000, n: 24};
    vecs[2] = '{data: 8'hA5, reps: 4'd0, bits: 32'hA500_0000, n: 8};
    vecs[3] = '{data: 8'h3C, reps: 4'd2, bits: 32'h3C3C_0000, n: 16};

    load_valid = 1'b0;
    load_data  = '0;
    load_reps  = '0;
    reset      = 1'b1;
    #1;
    chk("rst_out", {31'b0, out}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_ready", {31'b0, load_ready}, 32'd0);
    #1;
    reset = 1'b0;
    #1;
    chk("rel_ready", {31'b0, load_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_done", {31'b0, done}, 32'd0);
      chk("idle_valid", {31'b0, out_valid}, 32'd0);
    end

    foreach (vecs[k]) begin
      send(vecs[k].data, vecs[k].reps);
      recv($sformatf("vec%0d", k), vecs[k].bits, vecs[k].n);
      @(negedge clk);
      chk("done_pulse", {31'b0, done}, 32'd0);
    end

    // load held during a frame is ignored, then taken in the done cycle
    send(8'h0F, 4'd1);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    load_reps  = 4'd1;
    recv("hold0F", 32'h0F00_0000, 8);
    send(8'h81, 4'd1);
    recv("b2b81", 32'h8100_0000, 8);
    @(negedge clk);
    chk("b2b_end", {31'b0, done}, 32'd0);

    // reset in the middle of a frame
    send(8'hF0, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pre_rst_bit", {31'b0, out}, 32'd1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out", {31'b0, out}, 32'd0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, load_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, load_ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_done", {31'b0, done}, 32'd0);
      chk("post_rst_valid", {31'b0, out_valid}, 32'd0);
    end
    send(8'h01, 4'd1);
    recv("after_rst", 32'h0100_0000, 8);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
